// File: rtl/sdpram_fifo_ctrl_if.sv
// sdpram_fifo_ctrl_if: user-side write/read handshake and status bundle of the FIFO controller
interface sdpram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  overflow;
    logic                  underflow;
    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, data_count, overflow, underflow
    );
    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, data_count, overflow, underflow
    );
endinterface

// File: rtl/sdpram_fifo_ctrl.sv
// sdpram_fifo_ctrl: single-clock FIFO controller driving a combinational-read distributed SDP RAM; define FIFO_ERR_FLAG_EN for sticky overflow/underflow
module sdpram_fifo_ctrl #(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int ALMOST_FULL_NUM  = 12,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdpram_fifo_ctrl_if.slave     bus,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   AF_C    = ALMOST_FULL_NUM[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AE_C    = ALMOST_EMPTY_NUM[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  wa, ra;

    assign bus.full         = count == DEPTH_C;
    assign bus.empty        = count == '0;
    assign bus.almost_full  = count >= AF_C;
    assign bus.almost_empty = count <= AE_C;
    assign bus.data_count   = count;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;

    assign wa          = bus.wr_en & ~bus.full;
    assign ra          = bus.rd_en & ~bus.empty;
    assign ram_wr_en   = wa;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = bus.wr_data;
    assign ram_rd_addr = rd_ptr;

    // pointers and occupancy; flush wins over any same-cycle request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wa ? wr_ptr + PTR_ONE : wr_ptr;
            rd_ptr <= ra ? rd_ptr + PTR_ONE : rd_ptr;
            count  <= (wa && !ra) ? count + CNT_ONE : (ra && !wa) ? count - CNT_ONE : count;
        end
    end

    // capture the RAM word on each accepted read; data holds across a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= ra & ~bus.clr;
            rd_data_q  <= (ra && !bus.clr) ? ram_rd_data : rd_data_q;
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic ovf_q, unf_q;

    // sticky error flags, cleared only by reset or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (bus.wr_en & bus.full);
            unf_q <= unf_q | (bus.rd_en & bus.empty);
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule
